// File: rtl/rv32_mem_pkg.sv
// rv32_mem_pkg: shared funct3 width codes, responder state encoding and default LED address
package rv32_mem_pkg;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [31:0] LED_ADDRESS_DEFAULT = 32'h0000_0400;
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} mem_state_t;
endpackage

// File: rtl/memory_lane_align.sv
// memory_lane_align: byte-lane steering, load extension and alignment check for one access
module memory_lane_align
  import rv32_mem_pkg::*;
(
  input  logic [2:0]  width_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);
  logic [15:0] lane;
  assign lane = 16'(rdata_i >> {addr_i, 3'b000});
  // lane enables, replicated store data and extended load data
  always_comb begin
    be_o       = width_i == SB ? 4'b0001 << addr_i :
                 width_i == SH ? (addr_i[1] ? 4'b1100 : 4'b0011) :
                 width_i == SW ? 4'b1111 : 4'b0000;
    wdata_o    = width_i == SB ? {4{wdata_i[7:0]}} :
                 width_i == SH ? {2{wdata_i[15:0]}} : wdata_i;
    rdata_o    = width_i == LB  ? {{24{lane[7]}}, lane[7:0]} :
                 width_i == LBU ? {24'd0, lane[7:0]} :
                 width_i == LH  ? {{16{lane[15]}}, lane} :
                 width_i == LHU ? {16'd0, lane} :
                 width_i == LW  ? rdata_i : 32'd0;
    misalign_o = ((width_i == LH || width_i == LHU) && addr_i[0]) || (width_i == LW && addr_i != 2'b00);
  end
endmodule

// File: rtl/memory_responder.sv
// memory_responder: word RAM plus LED register behind a valid/ready request, one-cycle response port
module memory_responder
  import rv32_mem_pkg::*;
#(
  parameter int          WORDS       = 256,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] LED_ADDRESS = LED_ADDRESS_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [31:0] reqAddress,
  input  logic [2:0]  reqWidth,
  input  logic [31:0] reqWriteData,
  output logic        rspValid,
  output logic [31:0] rspReadData,
  output logic        rspError,
  output logic [31:0] LEDS
);
  localparam int AW = WORDS > 1 ? $clog2(WORDS) : 1;
  mem_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  width_q, width_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_err_q;
  logic [31:0] rsp_data_q, leds_q;
  logic [31:0] mem [WORDS];
  logic [AW-1:0] idx;
  logic        access, is_led, in_range, err, misalign, ram_we;
  logic [3:0]  be;
  logic [31:0] wd, rd_word, ext;
  assign reqReady    = state_q == IDLE;
  assign rspValid    = rsp_valid_q;
  assign rspReadData = rsp_data_q;
  assign rspError    = rsp_err_q;
  assign LEDS        = leds_q;
  assign access   = state_q == ACCESS;
  assign idx      = addr_q[AW+1:2];
  assign is_led   = addr_q == LED_ADDRESS;
  assign in_range = {2'b00, addr_q[31:2]} < 32'(WORDS);
  assign err      = misalign || width_q == 3'b011 || width_q[2:1] == 2'b11 || (write_q && width_q[2]) ||
                    (!in_range && !is_led) || (is_led && width_q != LW);
  assign rd_word  = is_led ? leds_q : mem[idx];
  assign ram_we   = access && write_q && !err && !is_led && !RESET;
  memory_lane_align u_align (
    .width_i   (width_q),
    .addr_i    (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .rdata_i   (rd_word),
    .be_o      (be),
    .wdata_o   (wd),
    .rdata_o   (ext),
    .misalign_o(misalign)
  );
  // next state: accept in IDLE, count down wait states, perform access for one cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    width_d = width_q;
    wdata_d = wdata_q;
    if (state_q == IDLE && reqValid) begin
      write_d = reqWrite;
      addr_d  = reqAddress;
      width_d = reqWidth;
      wdata_d = reqWriteData;
      cnt_d   = 4'(LATENCY);
      state_d = LATENCY == 0 ? ACCESS : WAIT;
    end else if (state_q == WAIT) begin
      cnt_d   = cnt_q - 4'd1;
      state_d = cnt_q == 4'd1 ? ACCESS : WAIT;
    end else if (state_q == ACCESS) begin
      state_d = IDLE;
    end
  end
  // state, wait counter and latched request
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      width_q <= width_d;
      wdata_q <= wdata_d;
    end
  end
  // registered response and LED register, both cleared by reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= 32'd0;
      leds_q      <= 32'd0;
    end else begin
      rsp_valid_q <= access;
      rsp_err_q   <= access && err;
      rsp_data_q  <= access && !err && !write_q ? ext : 32'd0;
      if (access && write_q && !err && is_led) leds_q <= wdata_q;
    end
  end
  // RAM byte-lane writes; contents survive reset
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 4; i++)
      if (ram_we && be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  end
endmodule
